mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing and arbitration controller in front of the unified 512-word instruction/data `memory` block. Shares the memory's single data port between two requesters: port 0, the CPU load/store unit, and port 1, the program loader/debug port. It uses round-robin arbitration with a valid/grant handshake and one-cycle-later read responses. It also range-checks instruction fetches and, optionally, runs a post-reset clear sweep. It exists because the memory writes on every edge where `data_op` is 0. The controller is therefore the only agent that may drive `data_op`, and it holds it at 1 (read) whenever no write is granted.

## Interface
- `MEM_WORDS`, 512: number of addressable words; a legal address is < MEM_WORDS.
- `CLEAR_ON_RESET`, 0: when 1, writes 0 to every word after reset release before accepting requests.
- `clk` input 1: clock; all state is updated on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `p0_req`, `p1_req` input 1 each: request valid; the request payload must stay stable until granted.
- `p0_we`, `p1_we` input 1 each: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` input 32 each: word address.
- `p0_wdata`, `p1_wdata` input 32 each: write data.
- `p0_gnt`, `p1_gnt` output 1 each: request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid` output 1 each: read response valid (registered).
- `p0_rdata`, `p1_rdata` output 32 each: read data, qualified by rvalid.
- `p0_err`, `p1_err` output 1 each: one-cycle pulse, coincident with the response slot, for an out-of-range access.
- `if_addr` input 32: instruction fetch word address.
- `if_err` output 1: registered; the previous cycle's `if_addr` was out of range.
- `busy` output 1: high during the clear sweep.
- `mem_data_op` output 1: to memory `data_op`; 1 = read, 0 = write.
- `mem_data_addr` output 32: to memory `data_addr`.
- `mem_write_val` output 32: to memory `write_val`.
- `mem_instruct_addr` output 32: to memory `instruct_addr`.
- `mem_read_val` input 32: from memory `read_val`.

## Operation
- States:
  - CLEAR: only entered when CLEAR_ON_RESET=1.
  - IDLE: grants are issued here.
  - RESP: read response cycle.
- **Reset (async assert):**
  - State: CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Round-robin pointer favours p0; clear counter = 0.
  - All gnt, rvalid, rdata and err outputs = 0; `if_err` = 0.
  - Memory side: `mem_data_op` = 1, `mem_data_addr` = 0, `mem_write_val` = 0.
  - An in-flight read is dropped; no rvalid is issued for it.
- **CLEAR:**
  - Each cycle: `mem_data_op` = 0, `mem_data_addr` = counter, `mem_write_val` = 0.
  - Counter increments each cycle; after writing address MEM_WORDS-1, state goes to IDLE.
  - `busy` = 1 and both gnt = 0 throughout.
- **IDLE, no request:** `mem_data_op` = 1, `mem_data_addr` = 0, `mem_write_val` = 0. No write may occur.
- **IDLE, arbitration:**
  - One request pending: it is granted.
  - Both pending: the port not granted most recently wins.
  - The pointer updates only on a grant.
- **Granted write, legal address:**
  - Same cycle: `mem_data_op` = 0, address and data driven.
  - Memory commits at the closing edge; state stays IDLE.
- **Granted read, legal address:**
  - Same cycle: `mem_data_op` = 1, address driven.
  - State goes to RESP.
- **Illegal address (≥ MEM_WORDS, unsigned 32-bit compare):**
  - Nothing is issued to memory; `mem_data_op` stays 1 and `mem_data_addr` = 0.
  - Write: `err` pulses in the next cycle; state stays IDLE.
  - Read: state goes to RESP; response has rdata = 0 and err = 1.
- **RESP:**
  - Granted port: rvalid = 1 and rdata = `mem_read_val` (0 for illegal).
  - Both gnt = 0; memory idles as in IDLE.
  - Next state is IDLE.
- **Instruction fetch:**
  - `mem_instruct_addr` = `if_addr` when legal, else 0.
  - `if_err` is registered from the range check.
  - Fetch never stalls and has no interaction with the data port.

## Timing
- Write: grant in cycle N; data visible to a read issued in cycle N+1 or later.
- Read: grant in cycle N; rvalid/rdata in cycle N+1; next grant no earlier than N+2. Peak rate is 1 read per 2 cycles.
- Writes sustain 1 per cycle.
- Fetch: `if_addr` in cycle N; instruction on memory `instruct_val` in N+1. `if_err` aligns with N+1.
- Read of a word written in the same cycle by a fetch-side address: the instruction port returns the old value (memory behaviour). This is accepted.
- Clear sweep lasts MEM_WORDS cycles; the first grant is possible in cycle MEM_WORDS after reset release.
- A request arriving in RESP or CLEAR waits; there is no combinational path from req to rvalid.

## Test plan
- **Write then read:** p0 write addr 7 with 0xDEADBEEF, then p0 read addr 7. Required: write grant in cycle N; read grant in N+1; p0_rvalid=1 with rdata=0xDEADBEEF in N+2.
- **Idle safety:** no requests for 20 cycles after a write of 0x1234 to addr 0. Required: `mem_data_op` stays 1 throughout; reading addr 0 afterwards returns 0x1234.
- **Contention:** p0 and p1 both request reads continuously.
  - Grants alternate p0, p1, p0 at 2-cycle spacing.
  - Each rvalid appears only on its own port, one cycle after its grant.
- **Out-of-range:**
  - p1 read addr 600: p1_rvalid=1, rdata=0, p1_err=1 next cycle; memory untouched.
  - p1 write addr 0xFFFFFFFF: p1_err pulse; `mem_data_op` stays 1.
- **Reset mid-read:** p0 read granted, then `reset` asserted low before the next edge. Required: no p0_rvalid; all outputs 0; `mem_data_op` = 1; after release the first grant occurs normally.
- **Clear with CLEAR_ON_RESET=1:**
  - `busy` high for exactly 512 cycles with gnt held 0.
  - Afterwards, reads of addr 3 and addr 511 return 0.
  - `if_addr` = 512 gives `if_err` = 1 one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: two valid/grant ports whose
// read responses come back one cycle after the grant.
interface mem_port_arbiter_if;
  logic        p0_req,    p1_req;
  logic        p0_we,     p1_we;
  logic [31:0] p0_addr,   p1_addr;
  logic [31:0] p0_wdata,  p1_wdata;
  logic        p0_gnt,    p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata,  p1_rdata;
  logic        p0_err,    p1_err;

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err
  );

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory data port, with fetch range check
// and an optional post-reset clear sweep. Owns data_op: it is 1 unless a write is issued.
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS      = 512,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave ports,
  input  logic [31:0]       if_addr,
  output logic              if_err,
  output logic              busy,
  output logic              mem_data_op,
  output logic [31:0]       mem_data_addr,
  output logic [31:0]       mem_write_val,
  output logic [31:0]       mem_instruct_addr,
  input  logic [31:0]       mem_read_val
);

  localparam int unsigned      CNT_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WORDS - 1);
  localparam logic [31:0]      WORDS_32 = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RESP
  } state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_e           state_q,   state_d;
  logic             prio_q,    prio_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]       rvalid_q,  rvalid_d;
  logic [1:0]       err_q,     err_d;
  logic             if_err_q,  if_err_d;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        sel;
  logic        sel_we;
  logic        sel_legal;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        if_legal;

  // prio_q names the port that wins a tie; it flips away from each grantee.
  assign req       = {ports.p1_req, ports.p0_req};
  assign sel       = (req == 2'b11) ? prio_q : req[1];
  assign sel_we    = sel ? ports.p1_we    : ports.p0_we;
  assign sel_addr  = sel ? ports.p1_addr  : ports.p0_addr;
  assign sel_wdata = sel ? ports.p1_wdata : ports.p0_wdata;
  assign sel_legal = sel_addr < WORDS_32;
  assign if_legal  = if_addr < WORDS_32;

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    clr_cnt_d     = clr_cnt_q;
    rvalid_d      = 2'b00;
    err_d         = 2'b00;
    if_err_d      = ~if_legal;
    gnt           = 2'b00;
    mem_data_op   = 1'b1;
    mem_data_addr = 32'd0;
    mem_write_val = 32'd0;
    // While reset is held everything, including the memory side, stays idle.
    if (reset) begin
      case (state_q)
        S_CLEAR: begin
          mem_data_op   = 1'b0;
          mem_data_addr = 32'(clr_cnt_q);
          clr_cnt_d     = clr_cnt_q + 1'b1;
          if (clr_cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt    = sel ? 2'b10 : 2'b01;
            prio_d = ~sel;
            if (sel_legal) begin
              mem_data_op   = ~sel_we;
              mem_data_addr = sel_addr;
              mem_write_val = sel_we ? sel_wdata : 32'd0;
            end else begin
              err_d = gnt;
            end
            if (!sel_we) begin
              rvalid_d = gnt;
              state_d  = S_RESP;
            end
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = RESET_STATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
      prio_q    <= 1'b0;
      clr_cnt_q <= '0;
      rvalid_q  <= 2'b00;
      err_q     <= 2'b00;
      if_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      if_err_q  <= if_err_d;
    end
  end

  // Out-of-range reads still get a response slot, but with zero data.
  assign ports.p0_gnt    = gnt[0];
  assign ports.p1_gnt    = gnt[1];
  assign ports.p0_rvalid = rvalid_q[0];
  assign ports.p1_rvalid = rvalid_q[1];
  assign ports.p0_rdata  = (rvalid_q[0] && !err_q[0]) ? mem_read_val : 32'd0;
  assign ports.p1_rdata  = (rvalid_q[1] && !err_q[1]) ? mem_read_val : 32'd0;
  assign ports.p0_err    = err_q[0];
  assign ports.p1_err    = err_q[1];

  assign busy              = reset && (state_q == S_CLEAR);
  assign if_err            = if_err_q;
  assign mem_instruct_addr = if_legal ? if_addr : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned WORDS = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_c;
  logic [31:0] if_addr, if_addr_c;
  logic        if_err, if_err_c, busy, busy_c;
  logic        op, op_c;
  logic [31:0] maddr, maddr_c, wval, wval_c, iaddr, iaddr_c;
  logic [31:0] rval, rval_c;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if bus_c();

  mem_port_arbiter #(.MEM_WORDS(WORDS), .CLEAR_ON_RESET(1'b0)) dut (
    .clk(clk), .reset(reset), .ports(bus), .if_addr(if_addr), .if_err(if_err),
    .busy(busy), .mem_data_op(op), .mem_data_addr(maddr), .mem_write_val(wval),
    .mem_instruct_addr(iaddr), .mem_read_val(rval)
  );

  mem_port_arbiter #(.MEM_WORDS(WORDS), .CLEAR_ON_RESET(1'b1)) dut_c (
    .clk(clk), .reset(reset_c), .ports(bus_c), .if_addr(if_addr_c), .if_err(if_err_c),
    .busy(busy_c), .mem_data_op(op_c), .mem_data_addr(maddr_c), .mem_write_val(wval_c),
    .mem_instruct_addr(iaddr_c), .mem_read_val(rval_c)
  );

  // Memory models: write on every edge with data_op=0, registered read (old value).
  logic [31:0] mem   [WORDS];
  bit          wr    [WORDS];
  logic [31:0] mem_c [WORDS];
  bit          wr_c  [WORDS];

  function automatic logic [31:0] initVal(input logic [8:0] i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!op) begin
      mem[maddr[8:0]] <= wval;
      wr[maddr[8:0]]  <= 1'b1;
    end
    rval <= wr[maddr[8:0]] ? mem[maddr[8:0]] : initVal(maddr[8:0]);
  end

  always @(posedge clk) begin
    if (!op_c) begin
      mem_c[maddr_c[8:0]] <= wval_c;
      wr_c[maddr_c[8:0]]  <= 1'b1;
    end
    rval_c <= wr_c[maddr_c[8:0]] ? mem_c[maddr_c[8:0]] : (32'hCAFE_0000 + 32'(maddr_c[8:0]));
  end

  typedef struct {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic [1:0] gnt, rv, er;
    logic [31:0] rd0, rd1;
    logic op;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.p0_req = v.r0; bus.p0_we = v.w0; bus.p0_addr = v.a0; bus.p0_wdata = v.d0;
    bus.p1_req = v.r1; bus.p1_we = v.w1; bus.p1_addr = v.a1; bus.p1_wdata = v.d1;
  endtask

  task automatic addVec(input logic r0, w0, input logic [31:0] a0, d0,
                        input logic r1, w1, input logic [31:0] a1, d1,
                        input logic [1:0] gnt, rv, er, input logic [31:0] rd0, rd1,
                        input logic op_e, input logic [31:0] maddr_e);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.gnt = gnt; v.rv = rv; v.er = er; v.rd0 = rd0; v.rd1 = rd1;
    v.op = op_e; v.maddr = maddr_e;
    vecs.push_back(v);
  endtask

  task automatic idleCycle();
    vec_t v;
    v.r0 = 0; v.w0 = 0; v.a0 = 0; v.d0 = 0; v.r1 = 0; v.w1 = 0; v.a1 = 0; v.d1 = 0;
    @(posedge clk); #1 applyStimulus(v);
  endtask

  function automatic logic [31:0] pickAddr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return 32'd32 + 32'($urandom_range(0, 15));
    if (r == 7) return 32'd511;
    if (r == 8) return ($urandom_range(0, 1) != 0) ? 32'd512 : 32'd600;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pickIfAddr();
    int r = $urandom_range(0, 3);
    if (r == 0) return 32'($urandom_range(0, 511));
    if (r == 1) return 32'd511;
    if (r == 2) return 32'd512;
    return $urandom();
  endfunction

  logic [31:0] ref_mem [WORDS];
  bit          pend [2];
  logic        we_r [2];
  logic [31:0] addr_r [2];
  logic [31:0] wd_r [2];
  logic [31:0] exp_rd [2];
  logic [1:0]  exp_rv, exp_er, exp_g;
  logic        turn, stall, prev_if_bad, has_win, win, legal;
  logic [31:0] cur_if;
  int          busy_cnt;
  bit          done;

  initial begin
    reset = 1'b0; reset_c = 1'b0; if_addr = 32'd0; if_addr_c = 32'd0;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 7; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
    bus_c.p0_req = 0; bus_c.p0_we = 0; bus_c.p0_addr = 0; bus_c.p0_wdata = 0;
    bus_c.p1_req = 0; bus_c.p1_we = 0; bus_c.p1_addr = 0; bus_c.p1_wdata = 0;

    // Reset state, with a request held to prove grants are suppressed.
    repeat (3) @(negedge clk);
    checkOutput("reset gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 0);
    checkOutput("reset rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 0);
    checkOutput("reset err", {30'd0, bus.p1_err, bus.p0_err}, 0);
    checkOutput("reset rdata0", bus.p0_rdata, 0);
    checkOutput("reset op", {31'd0, op}, 1);
    checkOutput("reset maddr", maddr, 0);
    checkOutput("reset wval", wval, 0);
    checkOutput("reset if_err", {31'd0, if_err}, 0);
    bus.p0_req = 0;
    @(posedge clk); #1 reset = 1'b1;

    //     r0 w0 a0    d0            r1 w1 a1            d1     gnt    rv     er     rd0           rd1       op maddr
    addVec(1, 1, 7,    32'hDEADBEEF, 0, 0, 0,            0,     2'b01, 2'b00, 2'b00, 0,            0,        0, 7);
    addVec(1, 0, 7,    0,            0, 0, 0,            0,     2'b01, 2'b00, 2'b00, 0,            0,        1, 7);
    addVec(0, 0, 0,    0,            0, 0, 0,            0,     2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 0,        1, 0);
    addVec(0, 0, 0,    0,            1, 1, 8,            'h808, 2'b10, 2'b00, 2'b00, 0,            0,        0, 8);
    addVec(1, 0, 7,    0,            1, 0, 8,            0,     2'b01, 2'b00, 2'b00, 0,            0,        1, 7);
    addVec(1, 0, 7,    0,            1, 0, 8,            0,     2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 0,        1, 0);
    addVec(1, 0, 7,    0,            1, 0, 8,            0,     2'b10, 2'b00, 2'b00, 0,            0,        1, 8);
    addVec(1, 0, 7,    0,            1, 0, 8,            0,     2'b00, 2'b10, 2'b00, 0,            'h808,    1, 0);
    addVec(1, 0, 7,    0,            1, 0, 8,            0,     2'b01, 2'b00, 2'b00, 0,            0,        1, 7);
    addVec(0, 0, 0,    0,            1, 0, 600,          0,     2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 0,        1, 0);
    addVec(0, 0, 0,    0,            1, 0, 600,          0,     2'b10, 2'b00, 2'b00, 0,            0,        1, 0);
    addVec(0, 0, 0,    0,            1, 1, 32'hFFFFFFFF, 'h55,  2'b00, 2'b10, 2'b10, 0,            0,        1, 0);
    addVec(0, 0, 0,    0,            1, 1, 32'hFFFFFFFF, 'h55,  2'b10, 2'b00, 2'b00, 0,            0,        1, 0);
    addVec(0, 0, 0,    0,            0, 0, 0,            0,     2'b00, 2'b00, 2'b10, 0,            0,        1, 0);
    addVec(1, 0, 511,  0,            0, 0, 0,            0,     2'b01, 2'b00, 2'b00, 0,            0,        1, 511);
    addVec(0, 0, 0,    0,            0, 0, 0,            0,     2'b00, 2'b01, 2'b00, 32'h100001FF, 0,        1, 0);
    addVec(0, 0, 0,    0,            0, 0, 0,            0,     2'b00, 2'b00, 2'b00, 0,            0,        1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d gnt", i), {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'(vecs[i].gnt));
      checkOutput($sformatf("row%0d rvalid", i), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'(vecs[i].rv));
      checkOutput($sformatf("row%0d err", i), {30'd0, bus.p1_err, bus.p0_err}, 32'(vecs[i].er));
      checkOutput($sformatf("row%0d op", i), {31'd0, op}, 32'(vecs[i].op));
      checkOutput($sformatf("row%0d maddr", i), maddr, vecs[i].maddr);
      if (vecs[i].rv[0]) checkOutput($sformatf("row%0d rdata0", i), bus.p0_rdata, vecs[i].rd0);
      if (vecs[i].rv[1]) checkOutput($sformatf("row%0d rdata1", i), bus.p1_rdata, vecs[i].rd1);
    end

    // Idle safety: a write, 20 quiet cycles, then read back.
    @(posedge clk); #1 bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 0; bus.p0_wdata = 32'h1234;
    @(negedge clk);
    checkOutput("idle write gnt", {31'd0, bus.p0_gnt}, 1);
    checkOutput("idle write op", {31'd0, op}, 0);
    for (int k = 0; k < 20; k++) begin
      idleCycle();
      @(negedge clk);
      checkOutput($sformatf("idle%0d op", k), {31'd0, op}, 1);
    end
    @(posedge clk); #1 bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 0;
    @(negedge clk);
    checkOutput("idle read gnt", {31'd0, bus.p0_gnt}, 1);
    idleCycle();
    @(negedge clk);
    checkOutput("idle read rvalid", {31'd0, bus.p0_rvalid}, 1);
    checkOutput("idle read rdata", bus.p0_rdata, 32'h1234);

    // Reset in the middle of a granted read drops its response.
    @(posedge clk); #1 bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 7;
    @(negedge clk);
    checkOutput("midrd gnt", {31'd0, bus.p0_gnt}, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrd rst gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 0);
    checkOutput("midrd rst rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 0);
    checkOutput("midrd rst op", {31'd0, op}, 1);
    checkOutput("midrd rst maddr", maddr, 0);
    bus.p0_req = 0;
    @(negedge clk);
    checkOutput("midrd no rvalid", {31'd0, bus.p0_rvalid}, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("midrd post rvalid", {31'd0, bus.p0_rvalid}, 0);
    @(posedge clk); #1 bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 8;
    @(negedge clk);
    checkOutput("midrd regrant", {30'd0, bus.p1_gnt, bus.p0_gnt}, 2);
    idleCycle();
    @(negedge clk);
    checkOutput("midrd rvalid1", {31'd0, bus.p1_rvalid}, 1);
    checkOutput("midrd rdata1", bus.p1_rdata, 32'h808);

    // Randomized traffic against a transaction-level model.
    idleCycle();
    if_addr = 32'd0;
    @(negedge clk); reset = 1'b0; #2 reset = 1'b1;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = initVal(9'(i));
    for (int p = 0; p < 2; p++) pend[p] = 0;
    turn = 0; stall = 0; exp_rv = 0; exp_er = 0; prev_if_bad = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      vec_t s;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) != 0) begin
          pend[p] = 1; we_r[p] = 1'($urandom_range(0, 1)); addr_r[p] = pickAddr(); wd_r[p] = $urandom();
        end
      end
      s.r0 = pend[0]; s.w0 = we_r[0]; s.a0 = addr_r[0]; s.d0 = wd_r[0];
      s.r1 = pend[1]; s.w1 = we_r[1]; s.a1 = addr_r[1]; s.d1 = wd_r[1];
      applyStimulus(s);
      cur_if = pickIfAddr();
      if_addr = cur_if;
      @(negedge clk);
      has_win = 0; win = 0;
      if (!stall && (pend[0] || pend[1])) begin
        has_win = 1;
        win = (pend[0] && pend[1]) ? turn : pend[1];
      end
      exp_g = has_win ? (win ? 2'b10 : 2'b01) : 2'b00;
      legal = has_win && (addr_r[win] < WORDS);
      checkOutput($sformatf("rand%0d gnt", cyc), {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'(exp_g));
      checkOutput($sformatf("rand%0d op", cyc), {31'd0, op}, (legal && we_r[win]) ? 0 : 1);
      checkOutput($sformatf("rand%0d rvalid", cyc), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'(exp_rv));
      checkOutput($sformatf("rand%0d err", cyc), {30'd0, bus.p1_err, bus.p0_err}, 32'(exp_er));
      if (exp_rv[0]) checkOutput($sformatf("rand%0d rdata0", cyc), bus.p0_rdata, exp_rd[0]);
      if (exp_rv[1]) checkOutput($sformatf("rand%0d rdata1", cyc), bus.p1_rdata, exp_rd[1]);
      checkOutput($sformatf("rand%0d if_err", cyc), {31'd0, if_err}, 32'(prev_if_bad));
      checkOutput($sformatf("rand%0d iaddr", cyc), iaddr, (cur_if < WORDS) ? cur_if : 0);
      exp_rv = 0; exp_er = 0; stall = 0;
      prev_if_bad = (cur_if >= WORDS);
      if (has_win) begin
        if (!legal) exp_er[win] = 1;
        if (we_r[win]) begin
          if (legal) ref_mem[addr_r[win][8:0]] = wd_r[win];
        end else begin
          exp_rv[win] = 1;
          exp_rd[win] = legal ? ref_mem[addr_r[win][8:0]] : 32'd0;
          stall = 1;
        end
        turn = ~win;
        pend[win] = 0;
      end
    end
    idleCycle();

    // Clear sweep on the CLEAR_ON_RESET instance.
    bus_c.p0_req = 1; bus_c.p0_we = 0; bus_c.p0_addr = 3;
    @(posedge clk); #1 reset_c = 1'b1;
    busy_cnt = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (busy_c) begin
        busy_cnt++;
        checkOutput($sformatf("clear%0d gnt", k), {31'd0, bus_c.p0_gnt}, 0);
      end else begin
        done = 1;
      end
    end
    checkOutput("clear busy cycles", 32'(busy_cnt), WORDS);
    checkOutput("clear first gnt", {31'd0, bus_c.p0_gnt}, 1);
    @(posedge clk); #1 bus_c.p0_addr = 511;
    @(negedge clk);
    checkOutput("clear rd3 rvalid", {31'd0, bus_c.p0_rvalid}, 1);
    checkOutput("clear rd3 rdata", bus_c.p0_rdata, 0);
    @(negedge clk);
    checkOutput("clear rd511 gnt", {31'd0, bus_c.p0_gnt}, 1);
    @(posedge clk); #1 bus_c.p0_req = 0; if_addr_c = 32'd512;
    @(negedge clk);
    checkOutput("clear rd511 rvalid", {31'd0, bus_c.p0_rvalid}, 1);
    checkOutput("clear rd511 rdata", bus_c.p0_rdata, 0);
    checkOutput("clear iaddr 512", iaddr_c, 0);
    @(posedge clk); #1 if_addr_c = 32'd0;
    @(negedge clk);
    checkOutput("clear if_err 512", {31'd0, if_err_c}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
